dcache_axi_read_arbiter: RTL and testbench
==========================================

Name: dcache_axi_read_arbiter

Overview:
- Shares one AXI read channel (AR and R) among several memory requesters. Requesters are the DCache miss unit, the PTW uncached path and the uncached load path. The shared channel goes to the L2/bus.
- Grants AR requests round-robin and tags each ID with the source index. Routes R beats back to their requester by that ID tag.
- Limits the number of outstanding bursts per requester.
- Sits between the DCache miss handling and the top-level AXI crossbar.

Parameters:
- MASTER_NUM, 3, number of requesters; index 0 is the DCache miss unit.
- MID_WIDTH, 4, requester-side AXI ID width.
- ADDR_WIDTH, 34, physical address width (PADDR_SIZE).
- DATA_WIDTH, 64, R data width (XLEN).
- MAX_OUTSTANDING, 2, maximum in-flight bursts per requester, range 1..3.
- SEL_WIDTH, $clog2(MASTER_NUM), width of the requester-index tag.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-low. Asserted when 0.
- m_ar_valid, input, MASTER_NUM, per-requester AR valid.
- m_ar_ready, output, MASTER_NUM, per-requester AR ready.
- m_ar_addr, input, MASTER_NUM x ADDR_WIDTH, AR address.
- m_ar_id, input, MASTER_NUM x MID_WIDTH, AR ID.
- m_ar_len, input, MASTER_NUM x 8, burst length minus 1.
- m_ar_size, input, MASTER_NUM x 3, beat size.
- m_ar_burst, input, MASTER_NUM x 2, burst type.
- m_r_valid, output, MASTER_NUM, per-requester R valid.
- m_r_ready, input, MASTER_NUM, per-requester R ready.
- m_r_data, output, DATA_WIDTH, R data, broadcast to all requesters.
- m_r_id, output, MID_WIDTH, R ID with the tag stripped.
- m_r_resp, output, 2, R response.
- m_r_last, output, 1, last beat of burst.
- s_ar_valid, output, 1, AR valid to the bus.
- s_ar_ready, input, 1, AR ready from the bus.
- s_ar_addr, output, ADDR_WIDTH, AR address to the bus.
- s_ar_id, output, SEL_WIDTH+MID_WIDTH, tagged AR ID.
- s_ar_len, output, 8, burst length minus 1.
- s_ar_size, output, 3, beat size.
- s_ar_burst, output, 2, burst type.
- s_r_valid, input, 1, R valid from the bus.
- s_r_ready, output, 1, R ready to the bus.
- s_r_data, input, DATA_WIDTH, R data.
- s_r_id, input, SEL_WIDTH+MID_WIDTH, tagged R ID.
- s_r_resp, input, 2, R response.
- s_r_last, input, 1, R last.
- err_bad_id, output, 1, one-cycle pulse when an R beat carries a tag >= MASTER_NUM.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE, rr_ptr=0, all outstanding counters=0, grant_idx=0.
  - s_ar_valid=0, all m_ar_ready=0, err_bad_id=0.
  - R-side outputs are combinational; with s_r_valid=0, all m_r_valid=0.
- Eligibility: requester i is eligible when m_ar_valid[i]=1 and out_cnt[i] < MAX_OUTSTANDING.
- State machine, IDLE:
  - If any requester is eligible, pick the first eligible index at or after rr_ptr, wrapping modulo MASTER_NUM.
  - Register the pick into grant_idx and move to GRANT.
  - No AR request reaches the bus in the pick cycle.
- State machine, GRANT:
  - s_ar_valid=1; s_ar_* carry requester grant_idx's fields.
  - s_ar_id = {grant_idx, m_ar_id[grant_idx]}.
  - m_ar_ready[grant_idx] = s_ar_ready; all other m_ar_ready=0.
  - Grant is locked: requesters must hold AR stable until their ready. The granted requester cannot be preempted until the handshake completes.
  - On s_ar_valid&s_ar_ready: out_cnt[grant_idx]++, rr_ptr=(grant_idx+1) mod MASTER_NUM, go to IDLE.
  - Minimum AR issue interval is 2 cycles.
- R routing (combinational):
  - sel = s_r_id[upper SEL_WIDTH bits].
  - If sel < MASTER_NUM: m_r_valid[sel]=s_r_valid, s_r_ready=m_r_ready[sel].
  - m_r_data, m_r_id (low MID_WIDTH bits), m_r_resp and m_r_last are broadcast.
- Bad tag: if s_r_valid=1 and sel >= MASTER_NUM:
  - s_r_ready=1 and the beat is dropped.
  - err_bad_id is a registered pulse, high in the next cycle.
  - No counter changes.
- Counters: out_cnt[i] decrements on s_r_valid&s_r_ready&s_r_last for sel=i.
  - AR increment and R-last decrement on the same requester in the same cycle leave the count unchanged.
  - Counter width is 2 bits; it never wraps because eligibility gates increments.
- Interleaving: R beats of different requesters may interleave; each requester sees only its own beats.

Test Plan:
- Single request: requester 0 asserts AR (addr 0x8000_0040, id 2, len 7). Then s_ar_valid rises 1 cycle later with s_ar_id=0x02. After s_ar_ready, an 8-beat R with id 0x02 reaches only requester 0, and out_cnt[0] goes 0->1->0.
- Round-robin: requesters 0, 1 and 2 are all valid continuously with s_ar_ready=1. Grants go 0,1,2,0, each 2 cycles apart, with s_ar_id tags 0x0_,0x1_,0x2_.
- Saturation: requester 1 issues 2 ARs with no R returned. A third AR from requester 1 is not granted while requester 2 is served. After requester 1's R last, its pending AR is granted.
- Same-cycle increment and decrement: requester 0 at out_cnt=1 gets an AR handshake in the same cycle as its R-last handshake. out_cnt[0] stays 1.
- Bad tag and backpressure:
  - An R beat with tag 3 (MASTER_NUM=3) gives s_r_ready=1 and err_bad_id high the next cycle.
  - An R beat for requester 2 with m_r_ready[2]=0 holds s_r_ready=0 until m_r_ready[2]=1.
- Reset mid-burst: rst goes low during GRANT with 3 R beats pending. All outputs go to 0 immediately. After release, state=IDLE, counters=0 and rr_ptr=0.

Source files
------------

// File: rtl/dcache_axi_read_arbiter.sv
// Shares one AXI read channel (AR + R) between several memory requesters.
// AR requests are granted round-robin. Each granted ID is prefixed with the
// requester index, and R beats are routed back to their requester by that
// prefix. Every requester may have at most MAX_OUTSTANDING bursts in flight.
module dcache_axi_read_arbiter #(
  parameter int MASTER_NUM      = 3,
  parameter int MID_WIDTH       = 4,
  parameter int ADDR_WIDTH      = 34,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2,
  parameter int SEL_WIDTH       = $clog2(MASTER_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // requester side
  input  logic [MASTER_NUM-1:0]                 m_ar_valid,
  output logic [MASTER_NUM-1:0]                 m_ar_ready,
  input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_ar_addr,
  input  logic [MASTER_NUM-1:0][MID_WIDTH-1:0]  m_ar_id,
  input  logic [MASTER_NUM-1:0][7:0]            m_ar_len,
  input  logic [MASTER_NUM-1:0][2:0]            m_ar_size,
  input  logic [MASTER_NUM-1:0][1:0]            m_ar_burst,
  output logic [MASTER_NUM-1:0]                 m_r_valid,
  input  logic [MASTER_NUM-1:0]                 m_r_ready,
  output logic [DATA_WIDTH-1:0]                 m_r_data,
  output logic [MID_WIDTH-1:0]                  m_r_id,
  output logic [1:0]                            m_r_resp,
  output logic                                  m_r_last,
  // bus side
  output logic                                  s_ar_valid,
  input  logic                                  s_ar_ready,
  output logic [ADDR_WIDTH-1:0]                 s_ar_addr,
  output logic [SEL_WIDTH+MID_WIDTH-1:0]        s_ar_id,
  output logic [7:0]                            s_ar_len,
  output logic [2:0]                            s_ar_size,
  output logic [1:0]                            s_ar_burst,
  input  logic                                  s_r_valid,
  output logic                                  s_r_ready,
  input  logic [DATA_WIDTH-1:0]                 s_r_data,
  input  logic [SEL_WIDTH+MID_WIDTH-1:0]        s_r_id,
  input  logic [1:0]                            s_r_resp,
  input  logic                                  s_r_last,
  output logic                                  err_bad_id
);

  localparam int                 TAG_WIDTH = SEL_WIDTH + MID_WIDTH;
  localparam logic [1:0]         MAX_OUT   = 2'(MAX_OUTSTANDING);
  localparam logic [SEL_WIDTH:0] NUM_TAGS  = (SEL_WIDTH + 1)'(MASTER_NUM);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(MASTER_NUM - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [SEL_WIDTH-1:0]   grant_idx_reg, grant_idx_next;
  logic [SEL_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
  logic                   err_bad_id_reg;

  logic [MASTER_NUM-1:0]  eligible;
  logic                   pick_found;
  logic [SEL_WIDTH-1:0]   pick_idx;
  logic [SEL_WIDTH-1:0]   cand_idx;
  logic                   ar_hs;
  logic [SEL_WIDTH-1:0]   r_sel;
  logic                   r_sel_ok;

  assign ar_hs    = s_ar_valid && s_ar_ready;
  assign r_sel    = s_r_id[TAG_WIDTH-1 -: SEL_WIDTH];
  assign r_sel_ok = {1'b0, r_sel} < NUM_TAGS;

  // Per-requester in-flight burst counters; eligibility gates increments, so
  // a counter never exceeds MAX_OUTSTANDING and cannot wrap.
  for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_req
    logic [1:0] cnt_reg;
    logic       inc;
    logic       dec;

    assign inc          = ar_hs && (grant_idx_reg == SEL_WIDTH'(gi));
    assign dec          = s_r_valid && s_r_ready && s_r_last && r_sel_ok
                          && (r_sel == SEL_WIDTH'(gi));
    assign eligible[gi] = m_ar_valid[gi] && (cnt_reg < MAX_OUT);

    // Count issued bursts up and completed bursts down; both at once cancel.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (inc && !dec) begin
        cnt_reg <= cnt_reg + 2'd1;
      end else if (dec && !inc) begin
        cnt_reg <= cnt_reg - 2'd1;
      end
    end
  end

  // Round-robin search: first eligible requester at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      cand_idx = SEL_WIDTH'((int'(rr_ptr_reg) + k) % MASTER_NUM);
      if (!pick_found && eligible[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Arbiter state register, plus the registered bad-tag pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_idx_reg  <= '0;
      rr_ptr_reg     <= '0;
      err_bad_id_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_idx_reg  <= grant_idx_next;
      rr_ptr_reg     <= rr_ptr_next;
      err_bad_id_reg <= s_r_valid && !r_sel_ok;
    end
  end

  // Next-state and AR handshake control; a grant stays locked until accepted.
  always_comb begin
    state_next     = state_reg;
    grant_idx_next = grant_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    s_ar_valid     = 1'b0;
    m_ar_ready     = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_idx_next = pick_idx;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        s_ar_valid                = 1'b1;
        m_ar_ready[grant_idx_reg] = s_ar_ready;
        if (s_ar_ready) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // AR payload of the granted requester; held at zero while no grant is active.
  always_comb begin
    s_ar_addr  = '0;
    s_ar_id    = '0;
    s_ar_len   = '0;
    s_ar_size  = '0;
    s_ar_burst = '0;
    if (state_reg == GRANT) begin
      s_ar_addr  = m_ar_addr[grant_idx_reg];
      s_ar_id    = {grant_idx_reg, m_ar_id[grant_idx_reg]};
      s_ar_len   = m_ar_len[grant_idx_reg];
      s_ar_size  = m_ar_size[grant_idx_reg];
      s_ar_burst = m_ar_burst[grant_idx_reg];
    end
  end

  // R routing by tag; beats with an unknown tag are accepted and dropped.
  always_comb begin
    m_r_valid = '0;
    s_r_ready = 1'b1;
    if (r_sel_ok) begin
      m_r_valid[r_sel] = s_r_valid;
      s_r_ready        = m_r_ready[r_sel];
    end
  end

  assign m_r_data   = s_r_data;
  assign m_r_id     = s_r_id[MID_WIDTH-1:0];
  assign m_r_resp   = s_r_resp;
  assign m_r_last   = s_r_last;
  assign err_bad_id = err_bad_id_reg;

endmodule

// File: tb/tb_dcache_axi_read_arbiter.sv
// Randomized bench for dcache_axi_read_arbiter: acts as requesters and as the
// bus slave, and checks every cycle against a transaction-level model.
module tb_dcache_axi_read_arbiter;
  localparam int MN   = 3;
  localparam int MIDW = 4;
  localparam int AW   = 34;
  localparam int DW   = 64;
  localparam int SELW = 2;
  localparam int TW   = SELW + MIDW;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [MN-1:0]          m_ar_valid, m_ar_ready;
  logic [MN-1:0][AW-1:0]  m_ar_addr;
  logic [MN-1:0][MIDW-1:0] m_ar_id;
  logic [MN-1:0][7:0]     m_ar_len;
  logic [MN-1:0][2:0]     m_ar_size;
  logic [MN-1:0][1:0]     m_ar_burst;
  logic [MN-1:0]          m_r_valid, m_r_ready;
  logic [DW-1:0]          m_r_data;
  logic [MIDW-1:0]        m_r_id;
  logic [1:0]             m_r_resp;
  logic                   m_r_last;
  logic                   s_ar_valid, s_ar_ready;
  logic [AW-1:0]          s_ar_addr;
  logic [TW-1:0]          s_ar_id;
  logic [7:0]             s_ar_len;
  logic [2:0]             s_ar_size;
  logic [1:0]             s_ar_burst;
  logic                   s_r_valid, s_r_ready;
  logic [DW-1:0]          s_r_data;
  logic [TW-1:0]          s_r_id;
  logic [1:0]             s_r_resp;
  logic                   s_r_last;
  logic                   err_bad_id;

  dcache_axi_read_arbiter #(
    .MASTER_NUM(MN), .MID_WIDTH(MIDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAXO), .SEL_WIDTH(SELW)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_id(m_ar_id), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_data(m_r_data), .m_r_id(m_r_id), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_id(s_ar_id), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_r_data(s_r_data), .s_r_id(s_r_id), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .err_bad_id(err_bad_id)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bursts in flight on the bus, per-requester counts,
  // round-robin pointer and the requester currently holding the grant.
  typedef struct {
    int         tag;
    logic [3:0] id;
    int         left;
  } burst_t;

  burst_t bq[$];
  int     mdl_cnt[MN];
  int     mdl_rr;
  int     mdl_grant;
  bit     mdl_err;
  bit     req_on[MN];
  bit     beat_on, beat_bad;
  int     beat_k;

  int ar_pct[MN];
  int rv_pct, bad_pct, rdy_pct, sar_pct;

  int         cyc;
  int         grant_tag[$];
  int         grant_cyc[$];
  logic [5:0] grant_id[$];
  int         dut_beats[MN];

  task automatic set_knobs(input int a0, input int a1, input int a2,
                           input int rv, input int bad, input int rdy, input int sar);
    ar_pct[0] = a0; ar_pct[1] = a1; ar_pct[2] = a2;
    rv_pct = rv; bad_pct = bad; rdy_pct = rdy; sar_pct = sar;
  endtask

  task automatic model_reset();
    bq.delete();
    for (int i = 0; i < MN; i++) begin
      mdl_cnt[i] = 0;
      req_on[i]  = 1'b0;
    end
    mdl_rr = 0; mdl_grant = -1; mdl_err = 1'b0;
    beat_on = 1'b0; beat_bad = 1'b0; beat_k = 0;
    m_ar_valid = '0; m_ar_addr = '0; m_ar_id = '0; m_ar_len = '0;
    m_ar_size = '0; m_ar_burst = '0; m_r_ready = '0;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0; s_r_id = '0;
    s_r_resp = '0; s_r_last = 1'b0;
  endtask

  // Requesters raise AR and hold it until accepted; slave returns beats of
  // any outstanding burst in any order, sometimes with an invalid tag.
  task automatic drive_inputs();
    for (int i = 0; i < MN; i++) begin
      if (!req_on[i] && int'($urandom_range(0, 99)) < ar_pct[i]) begin
        req_on[i]     = 1'b1;
        m_ar_addr[i]  = AW'({$urandom(), $urandom()});
        m_ar_id[i]    = 4'($urandom());
        m_ar_len[i]   = 8'($urandom_range(0, 3));
        m_ar_size[i]  = 3'd3;
        m_ar_burst[i] = 2'd1;
      end
      m_ar_valid[i] = req_on[i];
      m_r_ready[i]  = int'($urandom_range(0, 99)) < rdy_pct;
    end
    s_ar_ready = int'($urandom_range(0, 99)) < sar_pct;
    if (!beat_on) begin
      if (int'($urandom_range(0, 99)) < bad_pct) begin
        beat_on  = 1'b1;
        beat_bad = 1'b1;
        s_r_id   = {2'd3, 4'($urandom())};
        s_r_last = 1'($urandom());
      end else if (bq.size() > 0 && int'($urandom_range(0, 99)) < rv_pct) begin
        beat_on  = 1'b1;
        beat_bad = 1'b0;
        beat_k   = int'($urandom_range(0, bq.size() - 1));
        s_r_id   = {2'(bq[beat_k].tag), bq[beat_k].id};
        s_r_last = (bq[beat_k].left == 1);
      end
      s_r_data = {$urandom(), $urandom()};
      s_r_resp = 2'($urandom());
    end
    s_r_valid = beat_on;
  endtask

  task automatic check_and_model();
    logic [MN-1:0] exp_mar, exp_mrv;
    int     g, tag;
    bit     hs;
    burst_t b;
    if (s_ar_valid && s_ar_ready) begin
      grant_tag.push_back(int'(s_ar_id[5:4]));
      grant_cyc.push_back(cyc);
      grant_id.push_back(s_ar_id);
    end
    for (int i = 0; i < MN; i++)
      if (m_r_valid[i] && m_r_ready[i]) dut_beats[i]++;

    g = mdl_grant;
    check_eq("s_ar_valid", s_ar_valid, g >= 0);
    exp_mar = '0;
    if (g >= 0) begin
      exp_mar = 3'(s_ar_ready) << g;
      check_eq("s_ar_id", s_ar_id, {2'(g), m_ar_id[g]});
      check_eq("s_ar_addr", s_ar_addr, m_ar_addr[g]);
      check_eq("s_ar_len", s_ar_len, m_ar_len[g]);
    end
    check_eq("m_ar_ready", m_ar_ready, exp_mar);

    exp_mrv = '0;
    hs      = 1'b0;
    tag     = 3;
    if (beat_on) begin
      tag = beat_bad ? 3 : bq[beat_k].tag;
      hs  = beat_bad ? 1'b1 : m_r_ready[tag];
      check_eq("s_r_ready", s_r_ready, hs);
      if (!beat_bad) begin
        exp_mrv = 3'b001 << tag;
        check_eq("m_r_id", m_r_id, bq[beat_k].id);
        check_eq("m_r_data", m_r_data, s_r_data);
        check_eq("m_r_last", m_r_last, s_r_last);
      end
    end
    check_eq("m_r_valid", m_r_valid, exp_mrv);
    check_eq("err_bad_id", err_bad_id, mdl_err);
    mdl_err = beat_on && beat_bad;

    // pick uses the counts as they stand before this cycle's updates
    if (g < 0) begin
      for (int k = 0; k < MN; k++) begin
        int c;
        c = (mdl_rr + k) % MN;
        if (mdl_grant < 0 && req_on[c] && mdl_cnt[c] < MAXO) mdl_grant = c;
      end
    end
    if (beat_on && hs) begin
      if (!beat_bad) begin
        b = bq[beat_k];
        b.left--;
        if (b.left == 0) begin
          mdl_cnt[b.tag]--;
          bq.delete(beat_k);
        end else begin
          bq[beat_k] = b;
        end
      end
      beat_on = 1'b0;
    end
    if (g >= 0 && s_ar_ready) begin
      b.tag  = g;
      b.id   = m_ar_id[g];
      b.left = int'(m_ar_len[g]) + 1;
      bq.push_back(b);
      mdl_cnt[g]++;
      mdl_rr    = (g + 1) % MN;
      req_on[g] = 1'b0;
      mdl_grant = -1;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      drive_inputs();
      @(negedge clk);
      check_and_model();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic drain();
    int budget;
    bit busy;
    budget = 400;
    set_knobs(0, 0, 0, 100, 0, 100, 100);
    busy = 1'b1;
    while (busy && budget > 0) begin
      run_cycles(1);
      budget--;
      busy = bq.size() > 0 || beat_on || mdl_grant >= 0 || req_on[0] || req_on[1] || req_on[2];
    end
    check_eq("drain_done", busy, 1'b0);
  endtask

  function automatic int grants_to(input int base, input int who);
    int n;
    n = 0;
    for (int k = base; k < grant_tag.size(); k++)
      if (grant_tag[k] == who) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int base, t0;
    int rr_exp[4];
    cyc = 0;
    for (int i = 0; i < MN; i++) dut_beats[i] = 0;
    model_reset();
    rst = 1'b0;
    m_ar_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_ar_valid", s_ar_valid, 1'b0);
    check_eq("rst_m_ar_ready", m_ar_ready, 3'b000);
    check_eq("rst_err_bad_id", err_bad_id, 1'b0);
    check_eq("rst_m_r_valid", m_r_valid, 3'b000);
    m_ar_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // round robin from reset: 0,1,2,0 two cycles apart
    rr_exp = '{0, 1, 2, 0};
    set_knobs(100, 100, 100, 0, 0, 100, 100);
    base = grant_tag.size();
    run_cycles(14);
    check_eq("rr_count_ok", grant_tag.size() - base >= 4, 1'b1);
    if (grant_tag.size() - base >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("rr_tag", grant_tag[base + k], rr_exp[k]);
        if (k > 0) check_eq("rr_gap", grant_cyc[base + k] - grant_cyc[base + k - 1], 2);
      end
    end
    drain();

    // single request from requester 0: addr 0x8000_0040, id 2, len 7
    set_knobs(0, 0, 0, 0, 0, 100, 100);
    req_on[0] = 1'b1;
    m_ar_addr[0] = 34'h0_8000_0040;
    m_ar_id[0] = 4'd2;
    m_ar_len[0] = 8'd7;
    m_ar_size[0] = 3'd3;
    m_ar_burst[0] = 2'd1;
    base = grant_tag.size();
    t0 = cyc;
    run_cycles(2);
    check_eq("single_grants", grant_tag.size() - base, 1);
    if (grant_tag.size() - base == 1) begin
      check_eq("single_ar_id", grant_id[base], 6'h02);
      check_eq("single_latency", grant_cyc[base] - t0, 1);
    end
    for (int i = 0; i < MN; i++) dut_beats[i] = 0;
    set_knobs(0, 0, 0, 100, 0, 100, 100);
    run_cycles(12);
    check_eq("single_beats_r0", dut_beats[0], 8);
    check_eq("single_beats_r1_r2", dut_beats[1] + dut_beats[2], 0);
    drain();

    // saturation of requester 1, then release by its R last
    set_knobs(0, 100, 0, 0, 0, 100, 100);
    base = grant_tag.size();
    run_cycles(10);
    check_eq("sat_r1_grants", grants_to(base, 1), 2);
    base = grant_tag.size();
    set_knobs(0, 100, 100, 0, 0, 100, 100);
    run_cycles(8);
    check_eq("sat_r1_blocked", grants_to(base, 1), 0);
    check_eq("sat_r2_served", grants_to(base, 2) > 0, 1'b1);
    base = grant_tag.size();
    set_knobs(0, 0, 0, 100, 0, 100, 100);
    run_cycles(20);
    check_eq("sat_r1_released", grants_to(base, 1) > 0, 1'b1);
    drain();

    // randomized traffic with backpressure, bad tags and interleaving
    for (int s = 0; s < 6; s++) begin
      set_knobs(int'($urandom_range(20, 90)), int'($urandom_range(20, 90)),
                int'($urandom_range(20, 90)), int'($urandom_range(30, 90)),
                int'($urandom_range(0, 10)), int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)));
      run_cycles(400);
    end
    drain();

    // reset in the middle of a stalled grant with bursts in flight
    set_knobs(0, 0, 100, 0, 0, 100, 100);
    run_cycles(5);
    set_knobs(100, 0, 0, 0, 0, 100, 0);
    run_cycles(3);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_s_ar_valid", s_ar_valid, 1'b0);
    check_eq("midrst_m_ar_ready", m_ar_ready, 3'b000);
    check_eq("midrst_err_bad_id", err_bad_id, 1'b0);
    check_eq("midrst_m_r_valid", m_r_valid, 3'b000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    set_knobs(100, 100, 100, 0, 0, 100, 100);
    base = grant_tag.size();
    run_cycles(8);
    check_eq("postrst_count_ok", grant_tag.size() - base >= 3, 1'b1);
    if (grant_tag.size() - base >= 3) begin
      for (int k = 0; k < 3; k++) check_eq("postrst_tag", grant_tag[base + k], k);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
